axis_hdr_insert_arbiter: RTL
============================

// Module: axis_hdr_insert_arbiter
// PURPOSE
//  Shares one header-insert datapath between N_SRC packet sources. Each packet is one header beat plus payload beats ending in last.
//  Arbitrates round-robin, grants whole packets, and locks the grant until the payload last beat is accepted.
//  Drives the header (insert) port and the payload (in) port of the downstream axi_stream_insert_header instance.
// PARAMETERS
//  DATA_WD       32                   payload/header width in bits
//  DATA_BYTE_WD  DATA_WD/8            bytes per beat
//  BYTE_CNT_WD   $clog2(DATA_BYTE_WD) header byte-count width
//  N_SRC         4                    number of requesters, >=2
//  SRC_WD        $clog2(N_SRC)        grant index width
// PORTS
//  clk          in   1                     single clock, rising edge
//  rst_n        in   1                     asynchronous active-low reset
//  s_hdr_valid  in   N_SRC                 per-source header valid, which is the request
//  s_hdr_data   in   N_SRC*DATA_WD         per-source header; source i occupies slice [i*DATA_WD +: DATA_WD]
//  s_hdr_keep   in   N_SRC*DATA_BYTE_WD    per-source header keep
//  s_hdr_cnt    in   N_SRC*BYTE_CNT_WD     per-source header byte count
//  s_hdr_ready  out  N_SRC                 per-source header ready
//  s_valid      in   N_SRC                 per-source payload valid
//  s_data       in   N_SRC*DATA_WD         per-source payload data
//  s_keep       in   N_SRC*DATA_BYTE_WD    per-source payload keep
//  s_last       in   N_SRC                 per-source payload last
//  s_ready      out  N_SRC                 per-source payload ready
//  m_hdr_valid  out  1                     to valid_insert
//  m_hdr_data   out  DATA_WD               to data_insert
//  m_hdr_keep   out  DATA_BYTE_WD          to keep_insert
//  m_hdr_cnt    out  BYTE_CNT_WD           to byte_insert_cnt
//  m_hdr_ready  in   1                     from ready_insert
//  m_valid      out  1                     to valid_in
//  m_data       out  DATA_WD               to data_in
//  m_keep       out  DATA_BYTE_WD          to keep_in
//  m_last       out  1                     to last_in
//  m_ready      in   1                     from ready_in
//  grant_id     out  SRC_WD                currently or last granted source
//  busy         out  1                     1 when state != IDLE
//  pkt_cnt      out  16                    completed packets, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, grant_id=0, rr_last=N_SRC-1 (source 0 has top priority first), pkt_cnt=0.
//   - All m_* outputs and all s_*_ready outputs are 0.
//  FSM states: IDLE, HDR, PAY. State, grant_id, rr_last and pkt_cnt are registered; data muxes and readies are combinational.
//  IDLE:
//   - If any s_hdr_valid is set, pick the first set bit searching rr_last+1, rr_last+2, ... modulo N_SRC.
//   - Register it into grant_id and move to HDR.
//   - Arbitration costs exactly 1 cycle; no handshake happens in IDLE.
//  HDR:
//   - m_hdr_* = granted source's s_hdr_* slice.
//   - s_hdr_ready[g] = m_hdr_ready; s_hdr_ready of every other source = 0.
//   - On m_hdr_valid & m_hdr_ready, move to PAY.
//  PAY:
//   - m_valid/m_data/m_keep/m_last = granted slice; s_ready[g] = m_ready; all others 0. m_hdr_valid = 0.
//   - On m_valid & m_ready & m_last: move to IDLE, rr_last <= grant_id, pkt_cnt++.
//  Outside the owning state, m_hdr_* / m_* data buses and valids drive 0.
//  grant_id holds its value in IDLE until the next grant.
//  Requests arriving while busy are ignored until IDLE; a non-granted requester may drop or change its request freely.
//  The granted source dropping s_valid mid-packet stalls PAY indefinitely; there is no timeout and no preemption.
//  Back-to-back packets: the cycle after a last-beat handshake is always IDLE, so there is a 1-cycle bubble per packet.
//  Single-beat payload (s_last=1 on first beat) is legal: HDR -> PAY -> IDLE.
//  Keep and byte-count values pass through unmodified; s_hdr_cnt=0 is passed through.
//  Reset asserted mid-packet: immediate return to IDLE with reset values; the partial packet is abandoned.
//  No X propagation: unused source slices never reach m_*.
// TESTING
//  T1 Reset: rst_n=0 with s_hdr_valid=4'b1111 -> all readies/valids 0, pkt_cnt=0, grant_id=0.
//     Release -> grant_id=0 after 1 cycle.
//  T2 Round-robin: all 4 sources request continuously, 2-beat packets, m_ready=m_hdr_ready=1
//     -> grant order 0,1,2,3,0; pkt_cnt=5; each packet takes 4 cycles (IDLE, HDR, 2x PAY).
//  T3 Lock: src1 payload stalls (s_valid=0 for 10 cycles) while src2 requests -> src2 s_hdr_ready stays 0.
//     Src1 resumes and finishes -> next grant_id=2.
//  T4 Backpressure: m_hdr_ready=0 for 5 cycles in HDR -> m_hdr_data stays src slice, s_hdr_ready=0.
//     Then 1 -> PAY next cycle; m_ready toggled 1/0 -> no beat lost or duplicated (scoreboard per source).
//  T5 Reset mid-PAY: rst_n pulsed low for 1 cycle during beat 2 of 4 -> state IDLE, m_valid=0, pkt_cnt=0.
//  T6 Wrap: preload 65535 packets (force pkt_cnt=16'hFFFF), complete 1 packet -> pkt_cnt=0.

Source files
------------

// File: rtl/axis_hdr_insert_arbiter.sv
// axis_hdr_insert_arbiter
// Shares one header-insert datapath between N_SRC packet sources. Each packet
// is one header beat followed by payload beats ending in last. Sources are
// served round-robin. A grant covers a whole packet and is held until the last
// payload beat is accepted downstream.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_hdr_valid/data/keep/cnt       per-source header (valid is the request)
//   s_hdr_ready                     per-source header ready
//   s_valid/data/keep/last          per-source payload
//   s_ready                         per-source payload ready
//   m_hdr_valid/data/keep/cnt       header port toward the insert block
//   m_hdr_ready                     header ready from the insert block
//   m_valid/data/keep/last          payload port toward the insert block
//   m_ready                         payload ready from the insert block
//   grant_id                        currently or most recently granted source
//   busy                            high whenever a grant is held
//   pkt_cnt                         completed packets, wraps at 16 bits
//
// state | meaning
// IDLE  | no grant held; arbitrate among header requests (costs one cycle)
// HDR   | granted source's header routed to m_hdr_*, waiting for handshake
// PAY   | granted source's payload routed to m_*, until last beat accepted
module axis_hdr_insert_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int N_SRC        = 4,
  parameter int SRC_WD       = $clog2(N_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_SRC-1:0]                s_hdr_valid,
  input  logic [N_SRC*DATA_WD-1:0]        s_hdr_data,
  input  logic [N_SRC*DATA_BYTE_WD-1:0]   s_hdr_keep,
  input  logic [N_SRC*BYTE_CNT_WD-1:0]    s_hdr_cnt,
  output logic [N_SRC-1:0]                s_hdr_ready,
  input  logic [N_SRC-1:0]                s_valid,
  input  logic [N_SRC*DATA_WD-1:0]        s_data,
  input  logic [N_SRC*DATA_BYTE_WD-1:0]   s_keep,
  input  logic [N_SRC-1:0]                s_last,
  output logic [N_SRC-1:0]                s_ready,
  output logic                            m_hdr_valid,
  output logic [DATA_WD-1:0]              m_hdr_data,
  output logic [DATA_BYTE_WD-1:0]         m_hdr_keep,
  output logic [BYTE_CNT_WD-1:0]          m_hdr_cnt,
  input  logic                            m_hdr_ready,
  output logic                            m_valid,
  output logic [DATA_WD-1:0]              m_data,
  output logic [DATA_BYTE_WD-1:0]         m_keep,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SRC_WD-1:0]   rr_last;
  logic [SRC_WD-1:0]   pick;
  logic                pick_vld;
  logic [15:0]         pkt_cnt_q;
  logic [N_SRC-1:0]    grant_oh;
  logic                last_fire;

  // Granted source's slices, selected by one-hot compare so an index that
  // does not name a source can never pull in an unused slice.
  logic                    g_hdr_valid;
  logic [DATA_WD-1:0]      g_hdr_data;
  logic [DATA_BYTE_WD-1:0] g_hdr_keep;
  logic [BYTE_CNT_WD-1:0]  g_hdr_cnt;
  logic                    g_valid;
  logic [DATA_WD-1:0]      g_data;
  logic [DATA_BYTE_WD-1:0] g_keep;
  logic                    g_last;

  // Round-robin search starting just after the last source served.
  always_comb begin : arb
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(rr_last) + k) % N_SRC;
      if (!pick_vld && s_hdr_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = SRC_WD'(idx);
      end
    end
  end

  always_comb begin : gsel
    grant_oh    = '0;
    g_hdr_valid = 1'b0;
    g_hdr_data  = '0;
    g_hdr_keep  = '0;
    g_hdr_cnt   = '0;
    g_valid     = 1'b0;
    g_data      = '0;
    g_keep      = '0;
    g_last      = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_id == SRC_WD'(i)) begin
        grant_oh[i] = 1'b1;
        g_hdr_valid = s_hdr_valid[i];
        g_hdr_data  = s_hdr_data[i*DATA_WD +: DATA_WD];
        g_hdr_keep  = s_hdr_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        g_hdr_cnt   = s_hdr_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        g_valid     = s_valid[i];
        g_data      = s_data[i*DATA_WD +: DATA_WD];
        g_keep      = s_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        g_last      = s_last[i];
      end
    end
  end

  always_comb begin : fsm_comb
    state_nxt   = state;
    m_hdr_valid = 1'b0;
    m_hdr_data  = '0;
    m_hdr_keep  = '0;
    m_hdr_cnt   = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_keep      = '0;
    m_last      = 1'b0;
    s_hdr_ready = '0;
    s_ready     = '0;
    last_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = HDR;
      end
      HDR: begin
        m_hdr_valid = g_hdr_valid;
        m_hdr_data  = g_hdr_data;
        m_hdr_keep  = g_hdr_keep;
        m_hdr_cnt   = g_hdr_cnt;
        s_hdr_ready = grant_oh & {N_SRC{m_hdr_ready}};
        if (g_hdr_valid && m_hdr_ready) state_nxt = PAY;
      end
      PAY: begin
        m_valid = g_valid;
        m_data  = g_data;
        m_keep  = g_keep;
        m_last  = g_last;
        s_ready = grant_oh & {N_SRC{m_ready}};
        if (g_valid && m_ready && g_last) begin
          last_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_last   <= SRC_WD'(N_SRC - 1);
      pkt_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) grant_id <= pick;
      if (last_fire) begin
        rr_last   <= grant_id;
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign pkt_cnt = pkt_cnt_q;

endmodule
